mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter DEPTH_BYTES, 1024, byte capacity of the array; power of two, at least 8.
REQ-002 Parameter LATENCY, 2, cycles from request acceptance to the ready pulse; at least 1.
REQ-003 Parameter INIT_FILE, "extra_instructions.dat", hex image loaded byte-wise at time zero; empty string means no load.
REQ-004 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port rd_req, input, 1, read request; sampled only in IDLE.
REQ-007 Port wr_req, input, 1, write request; sampled only in IDLE.
REQ-008 Port addr, input, 32, byte address.
REQ-009 Port size, input, 2, access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 Port sext, input, 1, sign-extend byte/half loads when 1, zero-extend when 0.
REQ-011 Port wdata, input, 32, store data, right-justified for byte/half.
REQ-012 Port rdata, output, 32, load result.
REQ-013 Port ready, output, 1, one-cycle completion pulse.
REQ-014 Port err, output, 1, one-cycle error pulse, coincident with ready.
REQ-015 Port busy, output, 1, high in every state except IDLE.

Function
REQ-016 The array SHALL be little-endian: byte at addr holds bits 7:0, addr+3 holds bits 31:24.
REQ-017 FSM states SHALL be IDLE, BUSY, DONE.
REQ-018 In IDLE, rd_req or wr_req SHALL be accepted: addr, size, sext, wdata and the direction are latched; the FSM moves to BUSY (LATENCY>1) or DONE (LATENCY=1).
REQ-019 BUSY SHALL count down, entering DONE so that ready is high exactly LATENCY cycles after the accepting edge.
REQ-020 DONE SHALL last one cycle with ready=1, then return to IDLE; back-to-back requests therefore accept at most every LATENCY+1 cycles.
REQ-021 rd_req and wr_req both high in IDLE SHALL be accepted as an error request.
REQ-022 A request SHALL be an error if size=11, half addr[0]!=0, word addr[1:0]!=0, or addr+bytes > DEPTH_BYTES.
REQ-023 An error request SHALL run the same timing, raise err with ready, leave the array unmodified and leave rdata unchanged.
REQ-024 A valid write SHALL update only the addressed bytes, all in the DONE cycle edge.
REQ-025 A valid read SHALL load rdata on the DONE edge; byte/half results are extended per latched sext; rdata holds until the next valid read completes.
REQ-026 Requests and input changes while busy=1 SHALL be ignored; latched values govern the access.
REQ-027 Reads SHALL see the result of any write completed earlier.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, ready=0, err=0, busy=0, rdata=0, counter=0.
REQ-029 Reset mid-operation SHALL abort the access: no write performed, no ready pulse.
REQ-030 Array contents SHALL NOT be affected by reset; INIT_FILE loads only at time zero.

Verification
REQ-031 Word round trip, LATENCY=2: write 0xDEADBEEF at 0x10 -> ready 2 cycles after accept, err=0; read 0x10 -> rdata=0xDEADBEEF; byte 0x10 reads 0xEF.
REQ-032 Sub-word: sb 0x80 at 0x21 over word 0 -> word read 0x00008000; lb sext=1 at 0x21 -> 0xFFFFFF80; lbu -> 0x00000080; lh at 0x20 sext=1 -> 0xFFFF8000.
REQ-033 Errors: lw at 0x22, lh at 0x23, size=11, sw at 0x3FE (DEPTH 1024), rd_req and wr_req together -> each ready+err, memory and rdata unchanged.
REQ-034 Busy ignore: second wr_req 1 cycle after accept with different addr/data -> only first write occurs, one ready pulse.
REQ-035 Reset mid-write: assert rst_n=0 in BUSY of sw 0x12345678 at 0x40 -> outputs zero at once, 0x40 keeps prior value, no ready.
REQ-036 LATENCY=1 and LATENCY=4 builds: ready at exactly 1 and 4 cycles after accept; busy high for LATENCY cycles.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-addressed little-endian memory behind a fixed-latency request/ready handshake.
// Sub-word loads extend per sext; misaligned, out-of-range or conflicting requests complete with err.
module mem_ctrl #(
    parameter int    DEPTH_BYTES = 1024,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = "extra_instructions.dat"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_next_cnt;
    logic          w_accept;
    logic          w_access;

    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [1:0]    r_size;
    logic          r_sext;
    logic          r_write;
    logic          r_conflict;
    logic          r_err;
    logic [31:0]   r_rdata;

    logic [31:0]   w_op_addr;
    logic [31:0]   w_op_wdata;
    logic [1:0]    w_op_size;
    logic          w_op_sext;
    logic          w_op_write;
    logic          w_op_conflict;
    logic [2:0]    w_nbytes;
    logic          w_err;
    logic [AW-1:0] w_idx [4];
    logic [31:0]   w_word;
    logic [31:0]   w_load;
    logic          w_wr_en;

    logic [7:0]    r_mem [DEPTH_BYTES];

    // With LATENCY=1 the access happens on the accepting edge, so it must use the live inputs.
    assign w_op_addr     = (LATENCY == 1) ? addr              : r_addr;
    assign w_op_wdata    = (LATENCY == 1) ? wdata             : r_wdata;
    assign w_op_size     = (LATENCY == 1) ? size              : r_size;
    assign w_op_sext     = (LATENCY == 1) ? sext              : r_sext;
    assign w_op_write    = (LATENCY == 1) ? (wr_req & ~rd_req) : r_write;
    assign w_op_conflict = (LATENCY == 1) ? (wr_req & rd_req)  : r_conflict;

    always_comb begin
        case (w_op_size)
            2'b00:   w_nbytes = 3'd1;
            2'b01:   w_nbytes = 3'd2;
            default: w_nbytes = 3'd4;
        endcase
    end

    assign w_err = w_op_conflict
                || (w_op_size == 2'b11)
                || (w_op_size == 2'b01 && w_op_addr[0])
                || (w_op_size == 2'b10 && w_op_addr[1:0] != 2'b00)
                || (({1'b0, w_op_addr} + {30'd0, w_nbytes}) > 33'(DEPTH_BYTES));

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_idx[i] = w_op_addr[AW-1:0] + AW'(i);
        end
    end

    assign w_word = {r_mem[w_idx[3]], r_mem[w_idx[2]], r_mem[w_idx[1]], r_mem[w_idx[0]]};

    always_comb begin
        case (w_op_size)
            2'b00:   w_load = {{24{w_op_sext & w_word[7]}},  w_word[7:0]};
            2'b01:   w_load = {{16{w_op_sext & w_word[15]}}, w_word[15:0]};
            default: w_load = w_word;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            IDLE: begin
                if (rd_req || wr_req) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_next_state = DONE;
                        w_access     = 1'b1;
                    end else begin
                        w_next_state = BUSY;
                        w_next_cnt   = CW'(LATENCY - 2);
                    end
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_next_state = DONE;
                    w_access     = 1'b1;
                end else begin
                    w_next_cnt = r_cnt - CW'(1);
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= '0;
            r_sext     <= 1'b0;
            r_write    <= 1'b0;
            r_conflict <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_addr     <= addr;
                r_wdata    <= wdata;
                r_size     <= size;
                r_sext     <= sext;
                r_write    <= wr_req & ~rd_req;
                r_conflict <= wr_req & rd_req;
            end
            if (w_access) begin
                r_err <= w_err;
                if (!w_op_write && !w_err) begin
                    r_rdata <= w_load;
                end
            end
        end
    end

    assign w_wr_en = w_access & w_op_write & ~w_err;

    // NOTE: the array has no reset; its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < w_nbytes) begin
                    r_mem[w_idx[i]] <= w_op_wdata[8*i +: 8];
                end
            end
        end
    end

    assign busy  = (r_state != IDLE);
    assign ready = (r_state == DONE);
    assign err   = ready & r_err;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Drives LATENCY=1,2,4 builds of mem_ctrl in lockstep and checks them every cycle against
// a cycle-count/byte-array model, plus hand-computed load values and handshake timings.
module tb_mem_ctrl;

    localparam int DEPTH = 1024;
    localparam int NDUT  = 3;

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] wdata;
    logic [31:0] rdata_o [NDUT];
    logic        ready_o [NDUT];
    logic        err_o   [NDUT];
    logic        busy_o  [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_ctrl #(
            .DEPTH_BYTES(DEPTH),
            .LATENCY    (lat_of(g)),
            .INIT_FILE  ("")
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .rd_req(rd_req),
            .wr_req(wr_req),
            .addr  (addr),
            .size  (size),
            .sext  (sext),
            .wdata (wdata),
            .rdata (rdata_o[g]),
            .ready (ready_o[g]),
            .err   (err_o[g]),
            .busy  (busy_o[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Model: per-build byte array, expected load register and the in-flight request.
    logic [7:0]  mem_m     [NDUT][DEPTH];
    logic [31:0] exp_rdata [NDUT];
    bit          exp_err   [NDUT];
    bit          live      [NDUT];
    int          cyc = 0;
    int          acc = 0;
    bit          op_rd, op_wr, op_sext;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;

    int ready_cnt  [NDUT];
    int busy_cnt   [NDUT];
    int ready_edge [NDUT];
    bit err_seen   [NDUT];

    function automatic void commit(int k);
        int          nb;
        longint      a;
        logic [31:0] v;
        bit          e;
        a  = longint'(op_addr);
        nb = (op_size == 2'd0) ? 1 : (op_size == 2'd1) ? 2 : 4;
        e  = (op_rd && op_wr) || (op_size == 2'd3) || (a % nb != 0) || (a + nb > DEPTH);
        exp_err[k] = e;
        if (e) return;
        if (op_wr) begin
            for (int i = 0; i < nb; i++) mem_m[k][int'(a) + i] = op_wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v = v | (32'(mem_m[k][int'(a) + i]) << (8 * i));
            if (op_sext && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8 * nb));
            exp_rdata[k] = v;
        end
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // An accepted request is busy for LATENCY sampled cycles and ready on the last of them.
    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            int since;
            bit b;
            bit r;
            since = cyc - acc;
            if (live[k] && since == lat_of(k) - 1) commit(k);
            b = live[k] && since >= 0 && since < lat_of(k);
            r = live[k] && since == lat_of(k) - 1;
            check($sformatf("busy_L%0d",  lat_of(k)), 32'(busy_o[k]),  32'(b));
            check($sformatf("ready_L%0d", lat_of(k)), 32'(ready_o[k]), 32'(r));
            check($sformatf("err_L%0d",   lat_of(k)), 32'(err_o[k]),   32'(r && exp_err[k]));
            check($sformatf("rdata_L%0d", lat_of(k)), rdata_o[k],      exp_rdata[k]);
            if (ready_o[k] === 1'b1) begin
                ready_cnt[k]++;
                ready_edge[k] = cyc + 1;
            end
            if (busy_o[k] === 1'b1) busy_cnt[k]++;
            if (err_o[k] === 1'b1) err_seen[k] = 1'b1;
            if (live[k] && since >= lat_of(k) - 1) live[k] = 1'b0;
        end
    end

    task automatic issue(bit rd, bit wr, logic [31:0] a, logic [1:0] sz, bit sx, logic [31:0] wd);
        @(negedge clk);
        #1;
        rd_req = rd;
        wr_req = wr;
        addr   = a;
        size   = sz;
        sext   = sx;
        wdata  = wd;
        op_rd = rd; op_wr = wr; op_addr = a; op_size = sz; op_sext = sx; op_wdata = wd;
        acc = cyc + 1;
        for (int k = 0; k < NDUT; k++) begin
            live[k]       = 1'b1;
            ready_cnt[k]  = 0;
            busy_cnt[k]   = 0;
            ready_edge[k] = -1;
            err_seen[k]   = 1'b0;
        end
        @(negedge clk);
        #1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        addr   = $urandom;
        size   = 2'($urandom);
        sext   = 1'($urandom);
        wdata  = $urandom;
    endtask

    task automatic settle();
        repeat (5) @(negedge clk);
    endtask

    task automatic do_op(bit rd, bit wr, logic [31:0] a, logic [1:0] sz, bit sx, logic [31:0] wd);
        issue(rd, wr, a, sz, sx, wd);
        settle();
    endtask

    task automatic expect_rd(string name, logic [31:0] v);
        for (int k = 0; k < NDUT; k++) check($sformatf("%s_L%0d", name, lat_of(k)), rdata_o[k], v);
    endtask

    task automatic expect_err(string name, bit e);
        for (int k = 0; k < NDUT; k++) check($sformatf("%s_L%0d", name, lat_of(k)), 32'(err_seen[k]), 32'(e));
    endtask

    task automatic expect_zero_outputs(string name);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("%s_busy_L%0d",  name, lat_of(k)), 32'(busy_o[k]),  32'd0);
            check($sformatf("%s_ready_L%0d", name, lat_of(k)), 32'(ready_o[k]), 32'd0);
            check($sformatf("%s_err_L%0d",   name, lat_of(k)), 32'(err_o[k]),   32'd0);
            check($sformatf("%s_rdata_L%0d", name, lat_of(k)), rdata_o[k],      32'd0);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        rd_req = 1'b0;
        wr_req = 1'b0;
        addr   = '0;
        size   = '0;
        sext   = 1'b0;
        wdata  = '0;
        for (int k = 0; k < NDUT; k++) begin
            exp_rdata[k] = '0;
            exp_err[k]   = 1'b0;
            live[k]      = 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_m[k][i] = '0;
        end
        repeat (3) @(negedge clk);
        expect_zero_outputs("reset");
        #1 rst_n = 1'b1;

        // Word round trip and handshake timing.
        do_op(0, 1, 32'h10, 2'b10, 0, 32'hDEADBEEF);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("ready_after_accept_L%0d", lat_of(k)), 32'(ready_edge[k] - acc), 32'(lat_of(k)));
            check($sformatf("busy_cycles_L%0d", lat_of(k)), 32'(busy_cnt[k]), 32'(lat_of(k)));
        end
        expect_err("sw_err", 0);
        do_op(1, 0, 32'h10, 2'b10, 0, '0);
        expect_rd("lw_10", 32'hDEADBEEF);
        do_op(1, 0, 32'h10, 2'b00, 0, '0);
        expect_rd("lbu_10", 32'h000000EF);

        // Sub-word stores and sign/zero-extended loads.
        do_op(0, 1, 32'h20, 2'b10, 0, 32'h0);
        do_op(0, 1, 32'h21, 2'b00, 0, 32'hFFFFFF80);
        do_op(1, 0, 32'h20, 2'b10, 0, '0);
        expect_rd("lw_20", 32'h00008000);
        do_op(1, 0, 32'h21, 2'b00, 1, '0);
        expect_rd("lb_21", 32'hFFFFFF80);
        do_op(1, 0, 32'h21, 2'b00, 0, '0);
        expect_rd("lbu_21", 32'h00000080);
        do_op(0, 1, 32'h3FC, 2'b10, 0, 32'hCAFEF00D);
        do_op(1, 0, 32'h20, 2'b01, 1, '0);
        expect_rd("lh_20", 32'hFFFF8000);

        // Error requests: err with ready, no change to rdata or the array.
        do_op(1, 0, 32'h22, 2'b10, 0, '0);
        expect_err("lw_22_err", 1);
        expect_rd("lw_22_keep", 32'hFFFF8000);
        do_op(1, 0, 32'h23, 2'b01, 1, '0);
        expect_err("lh_23_err", 1);
        do_op(1, 0, 32'h20, 2'b11, 0, '0);
        expect_err("size11_err", 1);
        do_op(0, 1, 32'h3FE, 2'b10, 0, 32'h11111111);
        expect_err("sw_3fe_err", 1);
        do_op(1, 1, 32'h20, 2'b10, 0, 32'hFFFFFFFF);
        expect_err("rdwr_err", 1);
        expect_rd("err_keep", 32'hFFFF8000);
        do_op(1, 0, 32'h20, 2'b10, 0, '0);
        expect_rd("lw_20_after_err", 32'h00008000);
        do_op(1, 0, 32'h3FC, 2'b10, 0, '0);
        expect_rd("lw_3fc", 32'hCAFEF00D);
        expect_err("lw_3fc_err", 0);
        do_op(1, 0, 32'h3FF, 2'b00, 1, '0);
        expect_rd("lb_3ff", 32'hFFFFFFCA);

        // A second request while busy is ignored.
        do_op(0, 1, 32'h34, 2'b10, 0, 32'h0);
        issue(0, 1, 32'h30, 2'b10, 0, 32'h11223344);
        wr_req = 1'b1;
        addr   = 32'h34;
        size   = 2'b10;
        wdata  = 32'h55667788;
        @(negedge clk);
        #1 wr_req = 1'b0;
        settle();
        for (int k = 0; k < NDUT; k++)
            check($sformatf("one_ready_L%0d", lat_of(k)), 32'(ready_cnt[k]), 32'd1);
        do_op(1, 0, 32'h34, 2'b10, 0, '0);
        expect_rd("lw_34_untouched", 32'h00000000);
        do_op(1, 0, 32'h30, 2'b10, 0, '0);
        expect_rd("lw_30", 32'h11223344);

        // Reset during the write: aborted where still in flight, array survives reset.
        do_op(0, 1, 32'h40, 2'b10, 0, 32'h0BADCAFE);
        issue(0, 1, 32'h40, 2'b10, 0, 32'h12345678);
        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            live[k]      = 1'b0;
            exp_rdata[k] = '0;
        end
        #1;
        expect_zero_outputs("midreset");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        settle();
        check("midreset_ready_L1", 32'(ready_cnt[0]), 32'd1);
        check("midreset_ready_L2", 32'(ready_cnt[1]), 32'd0);
        check("midreset_ready_L4", 32'(ready_cnt[2]), 32'd0);
        do_op(1, 0, 32'h40, 2'b10, 0, '0);
        check("lw_40_L1", rdata_o[0], 32'h12345678);
        check("lw_40_L2", rdata_o[1], 32'h0BADCAFE);
        check("lw_40_L4", rdata_o[2], 32'h0BADCAFE);
        do_op(1, 0, 32'h10, 2'b01, 1, '0);
        expect_rd("lh_10", 32'hFFFFBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
